lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16, state width in bits; legal range 2..64.
REQ-002 Parameter POLY, default 16'h8005 (x^16+x^15+x^2+1), Galois feedback mask: bit k set = term x^k, k<WIDTH; bit 0 SHALL be set.
REQ-003 Parameter STEPS, default 1, single-bit shifts applied per advance; legal range 1..WIDTH.
REQ-004 Parameter SEED_RST, default 1, state after reset and the substitute for an all-zero seed; SHALL be nonzero.
REQ-005 Parameter CNT_W, default 32, width of the advance counter.
REQ-006 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_in  input  1  reset, asynchronous, active-high.
REQ-008 seed_in  input  WIDTH  seed value, sampled when seed_load_in=1.
REQ-009 seed_load_in  input  1  load request; seed is accepted in any cycle it is high.
REQ-010 ready_in  input  1  consumer accepts q_out this cycle.
REQ-011 q_out  output  WIDTH  current LFSR state.
REQ-012 valid_out  output  1  q_out holds a value not yet consumed.
REQ-013 wrap_out  output  1  one-cycle pulse: the state just returned to the loaded seed.
REQ-014 lock_err_out  output  1  one-cycle pulse: an all-zero seed was substituted.
REQ-015 adv_cnt_out  output  CNT_W  advances since the last seed load.

Function
REQ-016 Single-shift step: next = {s[WIDTH-2:0],1'b0} XOR (s[WIDTH-1] ? POLY : 0).
REQ-017 One advance SHALL apply the single-shift step STEPS times combinationally, completing in one clock.
REQ-018 An advance SHALL occur on a clock edge where valid_out=1, ready_in=1 and seed_load_in=0.
REQ-019 While valid_out=1 and ready_in=0, q_out, adv_cnt_out and the FSM SHALL hold.
REQ-020 FSM states: IDLE (valid_out=0) and RUN (valid_out=1); IDLE->RUN on the next edge when seed_load_in=0; RUN stays in RUN unless a seed is loaded.
REQ-021 Seed load (seed_load_in=1, any state): on the next edge, q_out SHALL take seed_in; the stored seed register SHALL take the same value; adv_cnt_out SHALL clear to 0; the FSM SHALL go to IDLE.
REQ-022 Seed load SHALL take priority over an advance in the same cycle; the pending q_out is discarded without being consumed.
REQ-023 All-zero seed_in: q_out and the stored seed SHALL take SEED_RST, and lock_err_out SHALL pulse high for the one cycle after the load edge.
REQ-024 wrap_out SHALL be high for exactly the one cycle after an advance whose result equals the stored seed; a seed load SHALL NOT raise wrap_out.
REQ-025 adv_cnt_out SHALL increment by 1 per advance, wrapping modulo 2^CNT_W.
REQ-026 The state SHALL never be all-zero.

Reset
REQ-027 While rst_in=1: q_out=SEED_RST, stored seed=SEED_RST, FSM=IDLE, valid_out=0, wrap_out=0, lock_err_out=0, adv_cnt_out=0; assertion takes effect without a clock edge.
REQ-028 After rst_in falls, valid_out SHALL rise on the first clock edge, with q_out=SEED_RST.
REQ-029 rst_in asserted mid-stream SHALL abort any handshake; no advance completes on that edge.

Verification
REQ-030 Defaults; load 16'h0001; then ready_in=1 for 3 advances -> q_out 0x0001, 0x0002, 0x0004, 0x0008; adv_cnt_out 0,1,2,3.
REQ-031 Defaults; load 16'h8000; 1 advance -> 0x8005. Load 16'hFFFF; 1 advance -> 0x7FFB.
REQ-032 Defaults; load 16'h0000 -> q_out=0x0001, lock_err_out high for 1 cycle, valid_out high one cycle later.
REQ-033 STEPS=2; load 16'h0001; 1 advance -> 0x0004. Then hold ready_in=0 for 5 cycles -> q_out stays 0x0004 and adv_cnt_out stays 1.
REQ-034 WIDTH=4, POLY=4'h3; load 4'h1; ready_in=1 continuously -> 15 distinct nonzero states; wrap_out pulses exactly after advance 15, then every 15 advances.
REQ-035 Assert rst_in asynchronously between edges mid-stream -> outputs take reset values immediately; seed_load_in and ready_in asserted together -> the load wins and adv_cnt_out=0.

Source files
------------

// File: rtl/lfsr_gen_if.sv
// Handshake bundle between the LFSR generator and its controller/consumer.
// The generator drives q_out/valid_out plus status pulses. A seed load is taken in
// any cycle it is high. A word is consumed on an edge with valid_out=1, ready_in=1
// and no seed load.
interface lfsr_gen_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 32
);
   logic [WIDTH-1:0] seed_in;
   logic             seed_load_in;
   logic             ready_in;
   logic [WIDTH-1:0] q_out;
   logic             valid_out;
   logic             wrap_out;
   logic             lock_err_out;
   logic [CNT_W-1:0] adv_cnt_out;
   logic             state_dbg;

   modport master (
      input  seed_in, seed_load_in, ready_in,
      output q_out, valid_out, wrap_out, lock_err_out, adv_cnt_out, state_dbg
   );

   modport slave (
      output seed_in, seed_load_in, ready_in,
      input  q_out, valid_out, wrap_out, lock_err_out, adv_cnt_out, state_dbg
   );
endinterface

// File: rtl/lfsr_gen.sv
// Galois LFSR generator with seed load and valid/ready output handshake.
// Each accepted word advances the state STEPS single-bit shifts in one clock.
module lfsr_gen #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] POLY     = WIDTH'(16'h8005),
   parameter int               STEPS    = 1,
   parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(1),
   parameter int               CNT_W    = 32
) (
   input  logic        clk_in,
   input  logic        rst_in,
   lfsr_gen_if.master  bus
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, seed_q, q_next, seed_fix;
   logic [CNT_W-1:0] cnt_q;
   logic             wrap_q, lock_q, advance;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] r;
      r = s;
      for (int i = 0; i < STEPS; i++) begin
         r = {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? POLY : '0);
      end
      return r;
   endfunction

   assign q_next   = lfsr_step(q_q);
   // An all-zero seed would lock the register, so it is replaced.
   assign seed_fix = (bus.seed_in == '0) ? SEED_RST : bus.seed_in;
   assign advance  = (state_q == RUN) && bus.ready_in && !bus.seed_load_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.seed_load_in)   state_d = IDLE;
      else if (state_q == IDLE) state_d = RUN;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         q_q    <= SEED_RST;
         seed_q <= SEED_RST;
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         lock_q <= 1'b0;
      end else if (bus.seed_load_in) begin
         q_q    <= seed_fix;
         seed_q <= seed_fix;
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         lock_q <= (bus.seed_in == '0);
      end else if (advance) begin
         q_q    <= q_next;
         cnt_q  <= cnt_q + CNT_W'(1);
         wrap_q <= (q_next == seed_q);
         lock_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         lock_q <= 1'b0;
      end
   end

   assign bus.q_out        = q_q;
   assign bus.valid_out    = (state_q == RUN);
   assign bus.wrap_out     = wrap_q;
   assign bus.lock_err_out = lock_q;
   assign bus.adv_cnt_out  = cnt_q;
   assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three configurations driven in lockstep and checked
// against a polynomial-arithmetic model (state = x^n * seed mod P(x)).
module tb_lfsr_gen;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   always #5 clk_in = ~clk_in;

   lfsr_gen_if #(.WIDTH(16), .CNT_W(32)) a0 ();
   lfsr_gen_if #(.WIDTH(16), .CNT_W(32)) a1 ();
   lfsr_gen_if #(.WIDTH(4),  .CNT_W(32)) a2 ();

   lfsr_gen d0 (.clk_in(clk_in), .rst_in(rst_in), .bus(a0.master));
   lfsr_gen #(.STEPS(2)) d1 (.clk_in(clk_in), .rst_in(rst_in), .bus(a1.master));
   lfsr_gen #(.WIDTH(4), .POLY(4'h3), .SEED_RST(4'h1)) d2 (.clk_in(clk_in), .rst_in(rst_in), .bus(a2.master));

   // model configuration per DUT
   int          cfg_w[3]     = '{16, 16, 4};
   logic [63:0] cfg_poly[3]  = '{64'h8005, 64'h8005, 64'h3};
   int          cfg_steps[3] = '{1, 2, 1};

   logic [63:0] m_q[3], m_seed[3];
   logic        m_wrap[3], m_lock[3];
   logic        m_valid;
   logic [31:0] m_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // multiply by x^n modulo x^w + poly
   function automatic logic [63:0] mulx(input logic [63:0] v, input int w, input logic [63:0] p, input int n);
      logic [64:0] t;
      t = {1'b0, v};
      for (int i = 0; i < n; i++) begin
         t = t << 1;
         if (t[w]) t = t ^ ((65'd1 << w) | {1'b0, p});
      end
      return t[63:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_q[i] = 64'd1; m_seed[i] = 64'd1; m_wrap[i] = 1'b0; m_lock[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_cnt   = '0;
   endtask

   task automatic check_dut(input int id, input logic [63:0] q, input logic v, input logic w,
                            input logic l, input logic [31:0] c);
      check_val($sformatf("q%0d", id), q, m_q[id]);
      check_val($sformatf("valid%0d", id), {63'd0, v}, {63'd0, m_valid});
      check_val($sformatf("wrap%0d", id), {63'd0, w}, {63'd0, m_wrap[id]});
      check_val($sformatf("lock%0d", id), {63'd0, l}, {63'd0, m_lock[id]});
      check_val($sformatf("cnt%0d", id), {32'd0, c}, {32'd0, m_cnt});
   endtask

   task automatic check_all();
      check_dut(0, {48'd0, a0.q_out}, a0.valid_out, a0.wrap_out, a0.lock_err_out, a0.adv_cnt_out);
      check_dut(1, {48'd0, a1.q_out}, a1.valid_out, a1.wrap_out, a1.lock_err_out, a1.adv_cnt_out);
      check_dut(2, {60'd0, a2.q_out}, a2.valid_out, a2.wrap_out, a2.lock_err_out, a2.adv_cnt_out);
   endtask

   // Called just after a falling edge: drive, model one rising edge, check at next falling edge.
   task automatic step(input logic ld, input logic [63:0] sd, input logic rdy);
      logic        adv;
      logic [63:0] s;
      a0.seed_load_in = ld; a1.seed_load_in = ld; a2.seed_load_in = ld;
      a0.ready_in = rdy;    a1.ready_in = rdy;    a2.ready_in = rdy;
      a0.seed_in = sd[15:0]; a1.seed_in = sd[15:0]; a2.seed_in = sd[3:0];
      adv = !ld && m_valid && rdy;
      for (int i = 0; i < 3; i++) begin
         m_wrap[i] = 1'b0;
         m_lock[i] = 1'b0;
         if (ld) begin
            s = sd & ((64'd1 << cfg_w[i]) - 64'd1);
            m_lock[i] = (s == 64'd0);
            if (s == 64'd0) s = 64'd1;
            m_q[i] = s;
            m_seed[i] = s;
         end else if (adv) begin
            m_q[i] = mulx(m_q[i], cfg_w[i], cfg_poly[i], cfg_steps[i]);
            m_wrap[i] = (m_q[i] == m_seed[i]);
         end
      end
      if (ld) begin
         m_valid = 1'b0;
         m_cnt = '0;
      end else if (adv) m_cnt = m_cnt + 32'd1;
      else m_valid = 1'b1;
      @(negedge clk_in);
      check_all();
   endtask

   int          wraps, first_wrap;
   logic [15:0] seen;
   logic [63:0] rs;

   initial begin
      a0.seed_load_in = 0; a1.seed_load_in = 0; a2.seed_load_in = 0;
      a0.ready_in = 0; a1.ready_in = 0; a2.ready_in = 0;
      a0.seed_in = '0; a1.seed_in = '0; a2.seed_in = '0;
      model_reset();
      repeat (2) @(negedge clk_in);
      check_all();
      rst_in = 1'b0;

      // first edge after reset raises valid with the reset seed
      step(0, 0, 0);
      check_val("rst_valid", {63'd0, a0.valid_out}, 64'd1);

      // load 1, three advances: 1,2,4,8 with counts 0..3
      step(1, 64'h0001, 0);
      step(0, 0, 0);
      check_val("v030_q0", {48'd0, a0.q_out}, 64'h0001);
      for (int i = 1; i <= 3; i++) step(0, 0, 1);
      check_val("v030_q3", {48'd0, a0.q_out}, 64'h0008);
      check_val("v030_cnt", {32'd0, a0.adv_cnt_out}, 64'd3);

      // feedback taps
      step(1, 64'h8000, 0); step(0, 0, 0); step(0, 0, 1);
      check_val("v031_a", {48'd0, a0.q_out}, 64'h8005);
      step(1, 64'hFFFF, 0); step(0, 0, 0); step(0, 0, 1);
      check_val("v031_b", {48'd0, a0.q_out}, 64'h7FFB);

      // all-zero seed substitution
      step(1, 64'h0000, 1);
      check_val("v032_q", {48'd0, a0.q_out}, 64'h0001);
      check_val("v032_lock", {63'd0, a0.lock_err_out}, 64'd1);
      check_val("v032_valid0", {63'd0, a0.valid_out}, 64'd0);
      step(0, 0, 0);
      check_val("v032_lock_clr", {63'd0, a0.lock_err_out}, 64'd0);
      check_val("v032_valid1", {63'd0, a0.valid_out}, 64'd1);

      // STEPS=2, then stall
      step(1, 64'h0001, 0); step(0, 0, 0); step(0, 0, 1);
      repeat (5) step(0, 0, 0);
      check_val("v033_q", {48'd0, a1.q_out}, 64'h0004);
      check_val("v033_cnt", {32'd0, a1.adv_cnt_out}, 64'd1);

      // 4-bit period: 15 distinct states, wrap after 15 and every 15
      step(1, 64'h0001, 0); step(0, 0, 0);
      wraps = 0; first_wrap = 0; seen = '0;
      for (int i = 1; i <= 45; i++) begin
         step(0, 0, 1);
         if (i <= 15) seen[a2.q_out] = 1'b1;
         if (a2.wrap_out) begin
            wraps++;
            if (first_wrap == 0) first_wrap = i;
         end
      end
      check_val("v034_distinct", 64'($countones(seen)), 64'd15);
      check_val("v034_zero", {63'd0, seen[0]}, 64'd0);
      check_val("v034_first", 64'(first_wrap), 64'd15);
      check_val("v034_wraps", 64'(wraps), 64'd3);

      // asynchronous reset mid-stream
      a0.ready_in = 1; a1.ready_in = 1; a2.ready_in = 1;
      #2 rst_in = 1'b1;
      #1 model_reset();
      check_all();
      @(negedge clk_in);
      check_all();
      rst_in = 1'b0;
      step(0, 0, 1);
      step(0, 0, 1);

      // load wins over advance
      step(0, 0, 1);
      step(1, 64'h1234, 1);
      check_val("v035_cnt", {32'd0, a0.adv_cnt_out}, 64'd0);
      check_val("v035_q", {48'd0, a0.q_out}, 64'h1234);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rs = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rs = 64'd0;
         step($urandom_range(0, 9) == 0, rs, $urandom_range(0, 2) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
